// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation
// encodings, FSM state encoding and the two's-complement magnitude helper.
package ex_muldiv_pkg;

    // Operation select values seen on i_op (6 and 7 are NOPs).
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Working width of the magnitude helper; operands are zero-extended into
    // it and the caller keeps the low BUS_SIZE bits (BUS_SIZE <= 64).
    localparam int MD_MAX_W = 128;

    // Two's-complement magnitude: negate when the operand is a negative
    // signed value. The most negative number maps onto itself, which read as
    // unsigned is exactly its magnitude.
    function automatic logic [MD_MAX_W-1:0] md_mag(
        input logic [MD_MAX_W-1:0] val,
        input logic                neg
    );
        logic [MD_MAX_W-1:0] res;
        if (neg) begin
            res = ~val + {{(MD_MAX_W-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_if #(
    parameter int BUS_SIZE = 32,
    parameter int OP_WIDTH = 3
);
    logic                i_start;
    logic [OP_WIDTH-1:0] i_op;
    logic                i_flush;
    logic [BUS_SIZE-1:0] i_data_A;
    logic [BUS_SIZE-1:0] i_data_B;
    logic                o_busy;
    logic                o_done;
    logic [BUS_SIZE-1:0] o_hi;
    logic [BUS_SIZE-1:0] o_lo;

    // EX stage / hazard logic side.
    modport master (
        output i_start, i_op, i_flush, i_data_A, i_data_B,
        input  o_busy, o_done, o_hi, o_lo
    );

    // Multiply/divide unit side.
    modport slave (
        input  i_start, i_op, i_flush, i_data_A, i_data_B,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/ex_muldiv_iter_step.sv
// One iteration of the magnitude datapath. The accumulator is {acc_hi, acc_lo}.
// Multiply: acc_lo holds the remaining multiplier bits; add opnd into the top
// half when the current multiplier bit is set, then shift right by one.
// Divide: acc_hi is the partial remainder, acc_lo the dividend bits still to
// be consumed; shift left by one, trial-subtract opnd, keep the difference
// when it does not borrow and shift the quotient bit into acc_lo.
module ex_muldiv_iter_step #(
    parameter int BUS_SIZE = 32
) (
    input  logic                mode_div,
    input  logic [BUS_SIZE-1:0] acc_hi,
    input  logic [BUS_SIZE-1:0] acc_lo,
    input  logic [BUS_SIZE-1:0] opnd,
    output logic [BUS_SIZE-1:0] nxt_hi,
    output logic [BUS_SIZE-1:0] nxt_lo
);
    logic [BUS_SIZE:0]   sum_s;
    logic [BUS_SIZE:0]   shifted_s;
    logic [BUS_SIZE+1:0] diff_s;
    logic                borrow_s;
    logic                diff_unused_s;

    // The partial remainder is always below opnd, so a non-borrowing
    // difference fits back into BUS_SIZE bits; bit BUS_SIZE is never needed.
    assign diff_unused_s = diff_s[BUS_SIZE];

    // Add-shift or trial-subtract for the current iteration.
    always_comb begin
        if (acc_lo[0]) begin
            sum_s = {1'b0, acc_hi} + {1'b0, opnd};
        end else begin
            sum_s = {1'b0, acc_hi};
        end
        shifted_s = {acc_hi, acc_lo[BUS_SIZE-1]};
        diff_s    = {1'b0, shifted_s} - {2'b00, opnd};
        borrow_s  = diff_s[BUS_SIZE+1];
        if (mode_div) begin
            if (borrow_s) begin
                nxt_hi = shifted_s[BUS_SIZE-1:0];
            end else begin
                nxt_hi = diff_s[BUS_SIZE-1:0];
            end
            nxt_lo = {acc_lo[BUS_SIZE-2:0], ~borrow_s};
        end else begin
            nxt_hi = sum_s[BUS_SIZE:1];
            nxt_lo = {sum_s[0], acc_lo[BUS_SIZE-1:1]};
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit beside the EX-stage ALU. Owns HI/LO, runs
// MULT/MULTU/DIV/DIVU on operand magnitudes over BUS_SIZE iterations, applies
// sign correction in a final FIX cycle and handles MTHI/MTLO immediately.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int BUS_SIZE = 32,
    parameter int OP_WIDTH = 3
) (
    input logic        i_clk,
    input logic        i_reset,
    ex_muldiv_if.slave md
);
    localparam int CNT_WIDTH = $clog2(BUS_SIZE) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BUS_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BUS_SIZE-1:0]  ONE_W    = {{(BUS_SIZE-1){1'b0}}, 1'b1};
    localparam logic [2*BUS_SIZE-1:0] ONE_2W  = {{(2*BUS_SIZE-1){1'b0}}, 1'b1};

    // Sequencer and datapath state
    md_state_e           state_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [BUS_SIZE-1:0] acc_hi_r;
    logic [BUS_SIZE-1:0] acc_lo_r;
    logic [BUS_SIZE-1:0] opnd_r;
    logic [BUS_SIZE-1:0] hi_r;
    logic [BUS_SIZE-1:0] lo_r;
    logic                neg_q_r;
    logic                neg_r_r;
    logic                dbz_r;
    logic                op_div_r;
    logic                busy_r;
    logic                done_r;

    // Request decode
    logic                op_mult_s, op_multu_s, op_div_s, op_divu_s;
    logic                op_mthi_s, op_mtlo_s, op_arith_s, op_signed_s, op_is_div_s;
    logic                neg_a_s, neg_b_s;
    logic [MD_MAX_W-1:0] mag_a_wide_s, mag_b_wide_s;
    logic [BUS_SIZE-1:0] mag_a_s, mag_b_s;
    logic                mag_unused_s;

    // Iteration datapath and final correction
    logic                step_div_s;
    logic [BUS_SIZE-1:0] step_hi_s, step_lo_s;
    logic [2*BUS_SIZE-1:0] prod_fix_s;
    logic [BUS_SIZE-1:0] quot_fix_s, rem_fix_s;
    logic [BUS_SIZE-1:0] fix_hi_s, fix_lo_s;

    assign mag_unused_s = ^{mag_a_wide_s[MD_MAX_W-1:BUS_SIZE],
                            mag_b_wide_s[MD_MAX_W-1:BUS_SIZE]};

    // Decode the requested op and form operand magnitudes and sign flags.
    always_comb begin
        op_mult_s   = (md.i_op == OP_WIDTH'(MD_MULT));
        op_multu_s  = (md.i_op == OP_WIDTH'(MD_MULTU));
        op_div_s    = (md.i_op == OP_WIDTH'(MD_DIV));
        op_divu_s   = (md.i_op == OP_WIDTH'(MD_DIVU));
        op_mthi_s   = (md.i_op == OP_WIDTH'(MD_MTHI));
        op_mtlo_s   = (md.i_op == OP_WIDTH'(MD_MTLO));
        op_arith_s  = op_mult_s | op_multu_s | op_div_s | op_divu_s;
        op_signed_s = op_mult_s | op_div_s;
        op_is_div_s = op_div_s | op_divu_s;
        neg_a_s     = op_signed_s & md.i_data_A[BUS_SIZE-1];
        neg_b_s     = op_signed_s & md.i_data_B[BUS_SIZE-1];
        mag_a_wide_s = md_mag({{(MD_MAX_W-BUS_SIZE){1'b0}}, md.i_data_A}, neg_a_s);
        mag_b_wide_s = md_mag({{(MD_MAX_W-BUS_SIZE){1'b0}}, md.i_data_B}, neg_b_s);
        mag_a_s     = mag_a_wide_s[BUS_SIZE-1:0];
        mag_b_s     = mag_b_wide_s[BUS_SIZE-1:0];
    end

    assign step_div_s = (state_r == ST_DIV);

    ex_muldiv_iter_step #(
        .BUS_SIZE (BUS_SIZE)
    ) u_step (
        .mode_div (step_div_s),
        .acc_hi   (acc_hi_r),
        .acc_lo   (acc_lo_r),
        .opnd     (opnd_r),
        .nxt_hi   (step_hi_s),
        .nxt_lo   (step_lo_s)
    );

    // Sign correction of the finished magnitude result. A zero divisor keeps
    // the all-ones quotient; the remainder correction restores the original A.
    always_comb begin
        if (neg_q_r) begin
            prod_fix_s = ~{acc_hi_r, acc_lo_r} + ONE_2W;
        end else begin
            prod_fix_s = {acc_hi_r, acc_lo_r};
        end
        if (neg_q_r && !dbz_r) begin
            quot_fix_s = ~acc_lo_r + ONE_W;
        end else begin
            quot_fix_s = acc_lo_r;
        end
        if (neg_r_r) begin
            rem_fix_s = ~acc_hi_r + ONE_W;
        end else begin
            rem_fix_s = acc_hi_r;
        end
        if (op_div_r) begin
            fix_hi_s = rem_fix_s;
            fix_lo_s = quot_fix_s;
        end else begin
            fix_hi_s = prod_fix_s[2*BUS_SIZE-1:BUS_SIZE];
            fix_lo_s = prod_fix_s[BUS_SIZE-1:0];
        end
    end

    // Sequencer: accept requests, iterate, correct and commit HI/LO.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_WIDTH{1'b0}};
            acc_hi_r <= {BUS_SIZE{1'b0}};
            acc_lo_r <= {BUS_SIZE{1'b0}};
            opnd_r   <= {BUS_SIZE{1'b0}};
            hi_r     <= {BUS_SIZE{1'b0}};
            lo_r     <= {BUS_SIZE{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dbz_r    <= 1'b0;
            op_div_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (md.i_flush) begin
                        // A coincident request is squashed.
                        state_r <= ST_IDLE;
                    end else if (md.i_start && op_arith_s) begin
                        acc_hi_r <= {BUS_SIZE{1'b0}};
                        acc_lo_r <= mag_a_s;
                        opnd_r   <= mag_b_s;
                        neg_q_r  <= neg_a_s ^ neg_b_s;
                        neg_r_r  <= neg_a_s;
                        dbz_r    <= op_is_div_s & (md.i_data_B == {BUS_SIZE{1'b0}});
                        op_div_r <= op_is_div_s;
                        cnt_r    <= {CNT_WIDTH{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= op_is_div_s ? ST_DIV : ST_MUL;
                    end else if (md.i_start && op_mthi_s) begin
                        hi_r <= md.i_data_A;
                    end else if (md.i_start && op_mtlo_s) begin
                        lo_r <= md.i_data_A;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md.i_flush) begin
                        busy_r  <= 1'b0;
                        cnt_r   <= {CNT_WIDTH{1'b0}};
                        state_r <= ST_IDLE;
                    end else begin
                        acc_hi_r <= step_hi_s;
                        acc_lo_r <= step_lo_s;
                        cnt_r    <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_FIX;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                end
                ST_FIX: begin
                    if (md.i_flush) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        hi_r    <= fix_hi_s;
                        lo_r    <= fix_lo_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    cnt_r <= {CNT_WIDTH{1'b0}};
                end
                default: begin
                    busy_r  <= 1'b0;
                    cnt_r   <= {CNT_WIDTH{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign md.o_busy = busy_r;
    assign md.o_done = done_r;
    assign md.o_hi   = hi_r;
    assign md.o_lo   = lo_r;

endmodule
